serial_word_receiver: RTL and testbench

Serial-to-parallel frame receiver that reassembles an N-bit word from a bit stream produced by the universal shift register's serial shift-out path. It takes one bit per qualified cycle, LSB-first or MSB-first selectable per frame, and presents the completed word on a registered output with a valid/ready handshake. It sits at the receiving end of the serial link, in front of any parallel consumer.

---
 rtl/serial_word_receiver.sv | 127 ++++++++++++
 tb/tb_serial_word_receiver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel frame receiver (optional even parity under PARITY_EN), one bit per sin_valid cycle.
// Latency: q_valid one cycle after last bit; backpressure: a word completing while q is unconsumed is dropped with overrun.
module serial_word_receiver #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         dir,
   input  logic         sin,
   input  logic         sin_valid,
   output logic [N-1:0] q,
   output logic         q_valid,
   input  logic         q_ready,
   output logic         busy,
   output logic         overrun,
   output logic         parity_err
);
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
`ifdef PARITY_EN
      , PAR = 2'd2
`endif
   } state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  sreg, sreg_nxt, shifted, word;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          dir_l, dir_nxt;
   logic          complete;
   logic          perr_calc;

   assign shifted = dir_l ? {sreg[N-2:0], sin} : {sin, sreg[N-1:1]};

   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = cnt;
      dir_nxt   = dir_l;
      complete  = 1'b0;
      word      = sreg;
      perr_calc = 1'b0;
      if (start) begin
         // start restarts from any state; a bit arriving on that cycle is discarded
         sreg_nxt  = '0;
         cnt_nxt   = '0;
         dir_nxt   = dir;
         state_nxt = SHIFT;
      end else begin
         case (state)
            SHIFT: begin
               if (sin_valid) begin
                  sreg_nxt = shifted;
                  cnt_nxt  = cnt + CW'(1);
                  if (cnt == CW'(N - 1)) begin
`ifdef PARITY_EN
                     state_nxt = PAR;
`else
                     complete  = 1'b1;
                     word      = shifted;
                     state_nxt = IDLE;
`endif
                  end
               end
            end
`ifdef PARITY_EN
            PAR: begin
               if (sin_valid) begin
                  complete  = 1'b1;
                  word      = sreg;
                  perr_calc = ^{sreg, sin};
                  state_nxt = IDLE;
               end
            end
`endif
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
         dir_l <= 1'b0;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
         cnt   <= cnt_nxt;
         dir_l <= dir_nxt;
      end
   end

   logic perr_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         q       <= '0;
         q_valid <= 1'b0;
         overrun <= 1'b0;
         perr_r  <= 1'b0;
      end else begin
         overrun <= complete && q_valid && !q_ready;
         if (complete && (!q_valid || q_ready)) begin
            q       <= word;
            q_valid <= 1'b1;
            perr_r  <= perr_calc;
         end else if (!complete && q_valid && q_ready) begin
            q_valid <= 1'b0;
            perr_r  <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

`ifdef PARITY_EN
   assign parity_err = perr_r;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomized self-checking bench for serial_word_receiver against a frame-level reference model.
module tb_serial_word_receiver;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst, start, dir, sin, sin_valid, q_ready;
   logic [N-1:0] q;
   logic         q_valid, busy, overrun, parity_err;

   int vectors = 0;
   int miscompares = 0;

   logic [N-1:0] exp_q;
   logic         exp_valid, exp_ov, exp_perr;

   serial_word_receiver #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .dir(dir), .sin(sin),
      .sin_valid(sin_valid), .q(q), .q_valid(q_valid), .q_ready(q_ready),
      .busy(busy), .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   // Word as seen by the consumer given the transmission order tx[0], tx[1], ...
   function automatic logic [N-1:0] ref_word(input logic d, input logic [N-1:0] tx);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (d) r[N-1-i] = tx[i];
         else   r[i]     = tx[i];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock: update the reference from what was driven, then check outputs.
   task automatic tick(input bit comp, input logic [N-1:0] w, input bit p, input bit eb);
      @(posedge clk);
      if (rst) begin
         exp_q = '0; exp_valid = 0; exp_ov = 0; exp_perr = 0;
      end else begin
         exp_ov = comp && exp_valid && !q_ready;
         if (comp && (!exp_valid || q_ready)) begin
            exp_q = w; exp_valid = 1; exp_perr = p;
         end else if (!comp && exp_valid && q_ready) begin
            exp_valid = 0; exp_perr = 0;
         end
      end
      #1;
      chk("q", 32'(q), 32'(exp_q));
      chk("q_valid", 32'(q_valid), 32'(exp_valid));
      chk("overrun", 32'(overrun), 32'(exp_ov));
      chk("parity_err", 32'(parity_err), 32'(exp_perr));
      chk("busy", 32'(busy), 32'(eb));
   endtask

   task automatic set_rdy(input int mode);
      if (mode == 2) q_ready = 1'($urandom_range(0, 1));
      else           q_ready = 1'(mode);
   endtask

   task automatic gaps(input int maxgap, input int mode);
      int g;
      g = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
      for (int k = 0; k < g; k++) begin
         sin_valid = 0; sin = 1'($urandom); set_rdy(mode);
         tick(0, '0, 0, 1);
      end
   endtask

   task automatic send_start(input logic d, input int mode);
      start = 1; dir = d; sin = 1'($urandom); sin_valid = 1'($urandom); set_rdy(mode);
      tick(0, '0, 0, 1);
      start = 0;
   endtask

   // Feed k bits of a frame without completing it.
   task automatic partial(input logic d, input int k);
      send_start(d, 0);
      for (int i = 0; i < k; i++) begin
         sin_valid = 1; sin = 1'($urandom);
         tick(0, '0, 0, 1);
      end
   endtask

   task automatic run_frame(input logic d, input logic [N-1:0] tx, input logic pb,
                            input int maxgap, input int mode, input bit rdy_end);
      logic [N-1:0] w;
      bit           last;
      w = ref_word(d, tx);
      send_start(d, mode);
      for (int i = 0; i < N; i++) begin
         gaps(maxgap, mode);
         sin_valid = 1; sin = tx[i];
`ifdef PARITY_EN
         last = 0;
`else
         last = (i == N - 1);
`endif
         if (last) q_ready = rdy_end; else set_rdy(mode);
         tick(last, w, 0, !last);
      end
`ifdef PARITY_EN
      gaps(maxgap, mode);
      sin_valid = 1; sin = pb; q_ready = rdy_end;
      tick(1, w, ^{tx, pb}, 0);
`else
      if (pb) sin = 0;
`endif
      sin_valid = 0;
   endtask

   task automatic consume();
      q_ready = 1; sin_valid = 0;
      tick(0, '0, 0, 0);
      q_ready = 0;
   endtask

   initial begin
      rst = 1; start = 0; dir = 0; sin = 0; sin_valid = 0; q_ready = 0;
      exp_q = '0; exp_valid = 0; exp_ov = 0; exp_perr = 0;
      tick(0, '0, 0, 0);
      tick(0, '0, 0, 0);
      rst = 0;

      // reset in the middle of a frame, then stray bits with no start are ignored
      partial(0, 2);
      rst = 1;
      tick(0, '0, 0, 0);
      rst = 0;
      sin_valid = 1; sin = 1;
      for (int i = 0; i < N + 1; i++) tick(0, '0, 0, 0);
      sin_valid = 0;
      run_frame(0, 4'b1101, 1, 0, 0, 0);
      chk("q_after_reset_frame", 32'(q), 32'h0000000d);
      consume();

      run_frame(0, 4'b0001, 1, 0, 0, 0);
      chk("lsb_first", 32'(q), 32'h00000001);
      consume();
      run_frame(1, 4'b0001, 1, 0, 0, 0);
      chk("msb_first", 32'(q), 32'h00000008);
      consume();

      run_frame(1, 4'b0110, 0, 3, 0, 0);
      chk("gapped", 32'(q), 32'h00000006);
      consume();

      // overrun: second word dropped while the first is held
      run_frame(0, 4'b0101, 0, 0, 0, 0);
      run_frame(0, 4'b1111, 0, 0, 0, 0);
      chk("held_word", 32'(q), 32'h00000005);
      consume();
      // ready on the completion cycle: replace without overrun
      run_frame(0, 4'b0101, 0, 0, 0, 0);
      run_frame(0, 4'b1111, 0, 0, 0, 1);
      chk("replaced_word", 32'(q), 32'h0000000f);
      consume();

      // restart after two bits
      partial(0, 2);
      run_frame(0, 4'b1010, 0, 0, 0, 0);
      chk("restart", 32'(q), 32'h0000000a);
      consume();

      // parity-bit cases (parity_err stays 0 without PARITY_EN)
      run_frame(0, 4'b1101, 1, 0, 0, 0);
      consume();
      run_frame(0, 4'b1101, 0, 0, 0, 0);
      consume();

      // back-to-back frames
      run_frame(0, 4'b0011, 0, 0, 1, 1);
      run_frame(1, 4'b1001, 1, 0, 1, 1);
      consume();

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) partial(1'($urandom), int'($urandom_range(0, N - 1)));
         run_frame(1'($urandom), N'($urandom), 1'($urandom), 2, 2, 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            sin_valid = 0; set_rdy(2);
            tick(0, '0, 0, 0);
         end
      end
      consume();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
